// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants for the I2S sample bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam logic I2S_CHAN_LEFT           = 1'b0;
    localparam int   I2S_SYNC_STAGES_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchroniser with registered-level edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect
    import i2s_pkg::*;
#(
    parameter int stages = I2S_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [stages-1:0] r_chain;
    logic              r_prev;

    // Free-running so the synchronised level is valid as soon as reset releases.
    always_ff @(posedge clk) begin
        r_chain <= {r_chain[stages-2:0], async_in};
        r_prev  <= r_chain[stages-1];
    end

    assign level = r_chain[stages-1];
    assign rise  = r_chain[stages-1] & ~r_prev;
    assign fall  = ~r_chain[stages-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2s_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sample_bridge
// Description : Slave-mode I2S bridge: left-channel RX to the engine, mono TX.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_sample_bridge
    import i2s_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int sync_stages = I2S_SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_din,
    output logic                  i2s_dout,
    output logic [data_width-1:0] sample_out,
    output logic                  sample_valid,
    input  logic [data_width-1:0] engine_sample,
    input  logic                  engine_ready,
    output logic                  overrun
);

    localparam int              c_CW       = $clog2(data_width + 1);
    localparam logic [c_CW-1:0] c_CNT_IDLE = c_CW'(data_width);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(data_width - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic w_bclk_rise;
    logic w_bclk_fall;
    logic w_bclk_level_unused;
    logic w_lr;
    logic w_lr_rise_unused;
    logic w_lr_fall_unused;
    logic w_din;
    logic w_slot_start;

    logic [sync_stages-1:0] r_din_sync;

    logic                  r_lr_prev;
    logic [c_CW-1:0]       r_rx_ctr;
    logic                  r_rx_chan;
    logic [data_width-2:0] r_rx_shift;
    logic [data_width-1:0] r_sample_out;
    logic                  r_sample_valid;
    logic                  r_overrun;

    logic                  r_ready_prev;
    logic [data_width-1:0] r_tx_word;
    logic [data_width-1:0] r_tx_frame;
    logic [data_width-1:0] r_tx_shift;
    logic [c_CW-1:0]       r_tx_ctr;
    logic                  r_dout;

    sync_edge_detect #(
        .stages   (sync_stages)
    ) u_bclk_sync (
        .clk      (clk),
        .async_in (i2s_bclk),
        .level    (w_bclk_level_unused),
        .rise     (w_bclk_rise),
        .fall     (w_bclk_fall)
    );

    sync_edge_detect #(
        .stages   (sync_stages)
    ) u_lrclk_sync (
        .clk      (clk),
        .async_in (i2s_lrclk),
        .level    (w_lr),
        .rise     (w_lr_rise_unused),
        .fall     (w_lr_fall_unused)
    );

    // Same depth as the bclk chain keeps din aligned with the detected rise.
    always_ff @(posedge clk) begin
        r_din_sync <= {r_din_sync[sync_stages-2:0], i2s_din};
    end
    assign w_din = r_din_sync[sync_stages-1];

    assign w_slot_start = w_bclk_rise && (w_lr != r_lr_prev);

    // Receive: the bit sampled at the slot-start rise is the previous slot's LSB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lr_prev      <= w_lr;
            r_rx_ctr       <= c_CNT_IDLE;
            r_rx_chan      <= ~I2S_CHAN_LEFT;
            r_rx_shift     <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
            if (w_bclk_rise) begin
                r_lr_prev <= w_lr;
                if (w_lr != r_lr_prev) begin
                    r_rx_ctr  <= '0;
                    r_rx_chan <= w_lr;
                end else if (r_rx_ctr < c_CNT_IDLE) begin
                    r_rx_shift <= {r_rx_shift[data_width-3:0], w_din};
                    r_rx_ctr   <= r_rx_ctr + c_CNT_ONE;
                    if ((r_rx_ctr == c_CNT_LAST) && (r_rx_chan == I2S_CHAN_LEFT)) begin
                        r_sample_out   <= {r_rx_shift, w_din};
                        r_sample_valid <= 1'b1;
                        r_overrun      <= ~engine_ready;
                    end
                end
            end
        end
    end

    // Transmit: one snapshot per frame, replayed on both slots.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready_prev <= engine_ready;
            r_tx_word    <= '0;
            r_tx_frame   <= '0;
            r_tx_shift   <= '0;
            r_tx_ctr     <= c_CNT_IDLE;
            r_dout       <= 1'b0;
        end else begin
            r_ready_prev <= engine_ready;
            if (engine_ready && !r_ready_prev) begin
                r_tx_word <= engine_sample;
            end
            if (w_slot_start) begin
                r_tx_ctr <= '0;
                if (w_lr == I2S_CHAN_LEFT) begin
                    r_tx_frame <= r_tx_word;
                    r_tx_shift <= r_tx_word;
                end else begin
                    r_tx_shift <= r_tx_frame;
                end
            end else if (w_bclk_fall) begin
                if (r_tx_ctr < c_CNT_IDLE) begin
                    r_dout     <= r_tx_shift[data_width-1];
                    r_tx_shift <= {r_tx_shift[data_width-2:0], 1'b0};
                    r_tx_ctr   <= r_tx_ctr + c_CNT_ONE;
                end else begin
                    r_dout <= 1'b0;
                end
            end
        end
    end

    assign i2s_dout     = r_dout;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_sample_bridge
// Description : Directed codec/engine bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_bridge;

    logic        clk           = 1'b0;
    logic        reset         = 1'b0;
    logic        i2s_bclk      = 1'b0;
    logic        i2s_lrclk     = 1'b1;
    logic        i2s_din       = 1'b0;
    logic        engine_ready  = 1'b1;
    logic [15:0] engine_sample = 16'h0000;
    logic        i2s_dout;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        overrun;

    int          vectors      = 0;
    int          miscompares  = 0;
    int          valid_cnt    = 0;
    int          overrun_cnt  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cmp_exp;
    logic [15:0] model_tx_word = 16'h0000;
    logic        last_bit      = 1'b0;
    logic [15:0] obs_slot      = 16'h0000;
    logic [15:0] obs_left      = 16'h0000;
    logic [15:0] obs_right     = 16'h0000;
    logic        dummy;

    always #5 clk = ~clk;

    i2s_sample_bridge #(
        .data_width    (16),
        .sync_stages   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_din       (i2s_din),
        .i2s_dout      (i2s_dout),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .engine_sample (engine_sample),
        .engine_ready  (engine_ready),
        .overrun       (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v, input logic [15:0] w);
        if (v && !engine_ready) model_tx_word = w;
        engine_sample = w;
        engine_ready  = v;
    endtask

    // One bclk period: fall (drive lrclk/din), codec samples dout just before the rise.
    task automatic drive_bit(input logic lr, input logic b, input logic exp, input bit chk,
                             input bit raise, input logic [15:0] rw, output logic obs);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_din   = b;
        if (raise) begin
            engine_ready  = 1'b0;
            engine_sample = rw;
        end
        wait_clk(8);
        if (chk) check("dout_bit", {31'd0, i2s_dout}, {31'd0, exp});
        obs = i2s_dout;
        i2s_bclk = 1'b1;
        if (raise) begin
            wait_clk(2);
            set_ready(1'b1, rw);
            wait_clk(6);
        end else begin
            wait_clk(8);
        end
    endtask

    task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw, input int n,
                              input bit chk, input int raise_pos, input logic [15:0] raise_word);
        logic [15:0] frame_tx;
        logic        lr;
        logic        sbit;
        logic        e;
        logic        o;
        int          j;
        frame_tx = model_tx_word;
        if (n >= 16) exp_q.push_back(lw);
        for (int p = 0; p < 2 * n; p++) begin
            lr   = (p >= n);
            j    = lr ? p - n : p;
            sbit = (j < 16) ? (lr ? rw[15-j] : lw[15-j]) : 1'b0;
            e    = (j >= 1 && j <= 16) ? frame_tx[16-j] : 1'b0;
            drive_bit(lr, last_bit, e, chk, p == raise_pos, raise_word, o);
            last_bit = sbit;
            if (j >= 1 && j <= 16) obs_slot = {obs_slot[14:0], o};
            if (j == 16) begin
                if (lr) obs_right = obs_slot;
                else    obs_left  = obs_slot;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("no_x", {31'd0, $isunknown({i2s_dout, sample_out, sample_valid, overrun})}, 32'd0);
            if (sample_valid) begin
                valid_cnt++;
                if (overrun) overrun_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    cmp_exp = exp_q.pop_front();
                    check("sample_out", {16'd0, sample_out}, {16'd0, cmp_exp});
                end
                check("overrun_with_valid", {31'd0, overrun}, {31'd0, !engine_ready});
            end else begin
                check("overrun_alone", {31'd0, overrun}, 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(10);
        check("rst_dout",   {31'd0, i2s_dout},     32'd0);
        check("rst_sample", {16'd0, sample_out},   32'd0);
        check("rst_valid",  {31'd0, sample_valid}, 32'd0);
        check("rst_ovr",    {31'd0, overrun},      32'd0);
        reset = 1'b1;
        wait_clk(4);

        // Left 0x8001 captured, right 0x7FFF dropped; engine word loaded mid-right slot.
        send_frame(16'h8001, 16'h7FFF, 32, 1, -1, 16'h0);
        check("valid_cnt_f1", valid_cnt, 1);
        check("sample_lit",   {16'd0, sample_out}, 32'h8001);
        check("tx_idle_lit",  {16'd0, obs_left},   32'h0000);
        send_frame(16'h8001, 16'h7FFF, 32, 1, 40, 16'hA5C3);
        send_frame(16'h8001, 16'h7FFF, 32, 1, -1, 16'h0);
        check("tx_left_lit",  {16'd0, obs_left},  32'hA5C3);
        check("tx_right_lit", {16'd0, obs_right}, 32'hA5C3);
        check("valid_cnt_p1", valid_cnt, 3);

        // Capture with the engine busy.
        set_ready(1'b0, 16'hA5C3);
        send_frame(16'h1357, 16'h2468, 32, 1, -1, 16'h0);
        set_ready(1'b1, 16'hA5C3);
        check("overrun_cnt", overrun_cnt, 1);
        check("valid_cnt_p2", valid_cnt, 4);

        // Short slots never complete a word.
        for (int k = 0; k < 3; k++) send_frame(16'hFFFF, 16'h0F0F, 12, 0, -1, 16'h0);
        check("valid_cnt_short", valid_cnt, 4);
        send_frame(16'h8001, 16'h7FFF, 32, 0, -1, 16'h0);
        check("valid_cnt_recover", valid_cnt, 5);

        // Reset in the middle of a left slot.
        for (int p = 0; p < 6; p++) drive_bit(1'b0, p[0], 1'b0, 1'b0, 1'b0, 16'h0, dummy);
        reset = 1'b0;
        wait_clk(3);
        check("mid_rst_dout",   {31'd0, i2s_dout},     32'd0);
        check("mid_rst_sample", {16'd0, sample_out},   32'd0);
        check("mid_rst_valid",  {31'd0, sample_valid}, 32'd0);
        check("mid_rst_ovr",    {31'd0, overrun},      32'd0);
        reset = 1'b1;
        model_tx_word = 16'h0000;
        for (int p = 6; p < 32; p++) drive_bit(1'b0, p[1], 1'b0, 1'b1, 1'b0, 16'h0, dummy);
        for (int p = 0; p < 32; p++) drive_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, dummy);
        check("valid_cnt_post_rst", valid_cnt, 5);
        last_bit = 1'b0;
        send_frame(16'h4321, 16'h7FFF, 32, 1, -1, 16'h0);
        check("valid_cnt_rst_frame", valid_cnt, 6);

        // Engine word arriving exactly at left slot start waits a frame.
        send_frame(16'h1111, 16'h2222, 32, 1, 40, 16'h0F0F);
        send_frame(16'h1111, 16'h2222, 32, 1, 0, 16'h1234);
        check("coinc_old_lit", {16'd0, obs_left}, 32'h0F0F);
        send_frame(16'h1111, 16'h2222, 32, 1, -1, 16'h0);
        check("coinc_new_left",  {16'd0, obs_left},  32'h1234);
        check("coinc_new_right", {16'd0, obs_right}, 32'h1234);

        wait_clk(20);
        check("queue_drained", exp_q.size(), 0);
        check("valid_cnt_end", valid_cnt, 9);
        check("overrun_cnt_end", overrun_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
